// File: rtl/gate_tt_sweeper.sv
// rtl/gate_tt_sweeper.sv - truth-table self-test sequencer for the NAND/NOR/XOR gate stage
// Optional feature macro: GATE_SWEEP_LOOP_EN (start held in DONE restarts the sweep directly)
module gate_tt_sweeper #(
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             e,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       fail_vec,
  output logic [2:0]       fail_bits
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [1:0]       vec_q;
  logic [HW-1:0]    hold_q;
  logic             a_q, b_q;
  logic             busy_q, done_q, pass_q;
  logic [ERR_W-1:0] err_q, err_d;
  logic [1:0]       fail_vec_q;
  logic [2:0]       fail_bits_q;

  logic [2:0] exp_bits;
  logic [2:0] diff_bits;
  logic       mismatch;
  logic       sample;
  logic       accept;

  // Expected values come from the registered stimulus so they line up with what the gate sees.
  always_comb begin
    exp_bits  = {~(a_q & b_q), ~(a_q | b_q), a_q ^ b_q};
    diff_bits = {c, d, e} ^ exp_bits;
    mismatch  = |diff_bits;
    sample    = (state_q == S_DRIVE) && (hold_q == HOLD_LAST);
    err_d     = err_q;
    if (mismatch && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + 1'b1;
    end
  end

`ifdef GATE_SWEEP_LOOP_EN
  assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
`else
  assign accept = start && (state_q == S_IDLE);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vec_q       <= 2'd0;
      hold_q      <= '0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      fail_vec_q  <= 2'd0;
      fail_bits_q <= 3'd0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        state_q     <= S_DRIVE;
        vec_q       <= 2'd0;
        hold_q      <= '0;
        a_q         <= 1'b0;
        b_q         <= 1'b0;
        busy_q      <= 1'b1;
        pass_q      <= 1'b0;
        err_q       <= '0;
        fail_vec_q  <= 2'd0;
        fail_bits_q <= 3'd0;
      end else begin
        case (state_q)
          S_IDLE: begin
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            busy_q <= 1'b0;
          end
          S_DRIVE: begin
            if (!sample) begin
              hold_q <= hold_q + 1'b1;
            end else begin
              err_q <= err_d;
              // err_count never returns to zero within a sweep, so zero marks "no mismatch yet".
              if (mismatch && (err_q == '0)) begin
                fail_vec_q  <= {a_q, b_q};
                fail_bits_q <= diff_bits;
              end
              hold_q <= '0;
              if (vec_q != 2'd3) begin
                vec_q <= vec_q + 2'd1;
                {a_q, b_q} <= vec_q + 2'd1;
              end else begin
                state_q <= S_DONE;
                vec_q   <= 2'd0;
                a_q     <= 1'b0;
                b_q     <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                pass_q  <= (err_d == '0);
              end
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_vec_q;
  assign fail_bits = fail_bits_q;

endmodule

// File: tb/tb_gate_tt_sweeper.sv
// tb/tb_gate_tt_sweeper.sv - scoreboard bench for gate_tt_sweeper with a faultable gate model
module tb_gate_tt_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, start_a, a_a, b_a, c_a, d_a, e_a, busy_a, done_a, pass_a;
  logic [3:0] err_a;
  logic [1:0] fvec_a;
  logic [2:0] fbits_a;
  logic       rst_b, start_b, a_b, b_b, c_b, d_b, e_b, busy_b, done_b, pass_b;
  logic [0:0] err_b;
  logic [1:0] fvec_b;
  logic [2:0] fbits_b;

  int fm_a, fm_b, sel;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] err;
    logic       pass;
    logic [1:0] fvec;
    logic [2:0] fbits;
    int         lat;
  } exp_t;
  exp_t       sb[$];
  logic [1:0] trace[$];
  int         obs_lat, obs_ndone;

  gate_tt_sweeper #(.HOLD_CYCLES(4), .ERR_W(4)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .a(a_a), .b(b_a), .c(c_a), .d(d_a), .e(e_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .fail_vec(fvec_a),
    .fail_bits(fbits_a));

  gate_tt_sweeper #(.HOLD_CYCLES(1), .ERR_W(1)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .a(a_b), .b(b_b), .c(c_b), .d(d_b), .e(e_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .fail_vec(fvec_b),
    .fail_bits(fbits_b));

  // Gate models: 0 = correct, 1 = e stuck at 0, 2 = all outputs inverted.
  always_comb begin
    {c_a, d_a, e_a} = {~(a_a & b_a), ~(a_a | b_a), a_a ^ b_a};
    if (fm_a == 1) e_a = 1'b0;
    if (fm_a == 2) {c_a, d_a, e_a} = ~{~(a_a & b_a), ~(a_a | b_a), a_a ^ b_a};
  end
  always_comb begin
    {c_b, d_b, e_b} = {~(a_b & b_b), ~(a_b | b_b), a_b ^ b_b};
    if (fm_b == 1) e_b = 1'b0;
    if (fm_b == 2) {c_b, d_b, e_b} = ~{~(a_b & b_b), ~(a_b | b_b), a_b ^ b_b};
  end

  logic       o_a, o_b, o_busy, o_done, o_pass;
  logic [3:0] o_err;
  logic [1:0] o_fvec;
  logic [2:0] o_fbits;
  always_comb begin
    if (sel == 0) begin
      {o_a, o_b, o_busy, o_done, o_pass} = {a_a, b_a, busy_a, done_a, pass_a};
      o_err = err_a; o_fvec = fvec_a; o_fbits = fbits_a;
    end else begin
      {o_a, o_b, o_busy, o_done, o_pass} = {a_b, b_b, busy_b, done_b, pass_b};
      o_err = {3'b000, err_b}; o_fvec = fvec_b; o_fbits = fbits_b;
    end
  end

  task automatic drive_start(input logic v);
    if (sel == 0) start_a = v;
    else start_b = v;
  endtask

  // One start pulse, then observe until done plus a short tail; extra!=0 pulses start while busy.
  task automatic sweep(input int extra);
    trace.delete();
    obs_lat   = -1;
    obs_ndone = 0;
    @(negedge clk);
    drive_start(1'b1);
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      if (o_busy) trace.push_back({o_a, o_b});
      if (o_done) begin
        obs_ndone++;
        if (obs_lat < 0) obs_lat = k;
      end
      drive_start((extra != 0 && obs_lat < 0 && (k % 2 == 1)) ? 1'b1 : 1'b0);
      if (obs_lat >= 0 && k >= obs_lat + 6) break;
    end
    drive_start(1'b0);
  endtask

  task automatic test_reset;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_a, b_a, busy_a, done_a, pass_a, err_a, fvec_a, fbits_a} !== 14'd0) begin
      errors++;
      $display("FAIL reset_a: got %0h expected 0",
               {a_a, b_a, busy_a, done_a, pass_a, err_a, fvec_a, fbits_a});
    end
    checks++;
    if ({a_b, b_b, busy_b, done_b, pass_b, err_b, fvec_b, fbits_b} !== 11'd0) begin
      errors++;
      $display("FAIL reset_b: got %0h expected 0",
               {a_b, b_b, busy_b, done_b, pass_b, err_b, fvec_b, fbits_b});
    end
    rst_a = 1'b0; rst_b = 1'b0;
  endtask

  task automatic test_basic;
    exp_t x;
    logic [1:0] et[$];
    sel = 0; fm_a = 0;
    sb.push_back('{err: 4'd0, pass: 1'b1, fvec: 2'd0, fbits: 3'd0, lat: 17});
    for (int v = 0; v < 4; v++) for (int h = 0; h < 4; h++) et.push_back(2'(v));
    sweep(0);
    x = sb.pop_front();
    checks++;
    if (obs_lat !== x.lat) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", obs_lat, x.lat); end
    checks++;
    if (obs_ndone !== 1) begin errors++; $display("FAIL basic_ndone: got %0d expected 1", obs_ndone); end
    checks++;
    if (trace.size() !== et.size()) begin
      errors++; $display("FAIL basic_trace_len: got %0d expected %0d", trace.size(), et.size());
    end else begin
      for (int i = 0; i < et.size(); i++)
        if (trace[i] !== et[i]) begin
          errors++; $display("FAIL basic_trace[%0d]: got %0d expected %0d", i, trace[i], et[i]); break;
        end
    end
    checks++;
    if ({o_err, o_pass, o_fvec, o_fbits} !== {x.err, x.pass, x.fvec, x.fbits}) begin
      errors++;
      $display("FAIL basic_result: got err=%0d pass=%0d fv=%0d fb=%0d expected err=%0d pass=%0d fv=%0d fb=%0d",
               o_err, o_pass, o_fvec, o_fbits, x.err, x.pass, x.fvec, x.fbits);
    end
  endtask

  task automatic test_e_stuck;
    exp_t x;
    sel = 0; fm_a = 1;
    sb.push_back('{err: 4'd2, pass: 1'b0, fvec: 2'b01, fbits: 3'b001, lat: 17});
    sweep(0);
    x = sb.pop_front();
    checks++;
    if (obs_lat !== x.lat) begin errors++; $display("FAIL estuck_latency: got %0d expected %0d", obs_lat, x.lat); end
    checks++;
    if ({o_err, o_pass, o_fvec, o_fbits} !== {x.err, x.pass, x.fvec, x.fbits}) begin
      errors++;
      $display("FAIL estuck_result: got err=%0d pass=%0d fv=%0d fb=%0d expected err=%0d pass=%0d fv=%0d fb=%0d",
               o_err, o_pass, o_fvec, o_fbits, x.err, x.pass, x.fvec, x.fbits);
    end
    fm_a = 0;
  endtask

  task automatic test_saturate;
    exp_t x;
    sel = 1; fm_b = 2;
    sb.push_back('{err: 4'd1, pass: 1'b0, fvec: 2'b00, fbits: 3'b111, lat: 5});
    sweep(0);
    x = sb.pop_front();
    checks++;
    if ({o_err, o_pass, o_fvec, o_fbits} !== {x.err, x.pass, x.fvec, x.fbits}) begin
      errors++;
      $display("FAIL saturate_result: got err=%0d pass=%0d fv=%0d fb=%0d expected err=%0d pass=%0d fv=%0d fb=%0d",
               o_err, o_pass, o_fvec, o_fbits, x.err, x.pass, x.fvec, x.fbits);
    end
    fm_b = 0;
  endtask

  task automatic test_hold1_busy_start;
    exp_t x;
    sel = 1; fm_b = 0;
    sb.push_back('{err: 4'd0, pass: 1'b1, fvec: 2'd0, fbits: 3'd0, lat: 5});
    sweep(1);
    x = sb.pop_front();
    checks++;
    if (obs_lat !== x.lat) begin errors++; $display("FAIL hold1_latency: got %0d expected %0d", obs_lat, x.lat); end
    checks++;
    if (obs_ndone !== 1) begin errors++; $display("FAIL hold1_ndone: got %0d expected 1", obs_ndone); end
    checks++;
    if (trace.size() !== 4) begin
      errors++; $display("FAIL hold1_trace_len: got %0d expected 4", trace.size());
    end else begin
      for (int i = 0; i < 4; i++)
        if (trace[i] !== 2'(i)) begin
          errors++; $display("FAIL hold1_trace[%0d]: got %0d expected %0d", i, trace[i], i); break;
        end
    end
    checks++;
    if ({o_err, o_pass} !== {x.err, x.pass}) begin
      errors++; $display("FAIL hold1_result: got err=%0d pass=%0d expected err=%0d pass=%0d", o_err, o_pass, x.err, x.pass);
    end
  endtask

  task automatic test_reset_mid;
    exp_t x;
    int found = 0;
    int seen_done = 0;
    sel = 0; fm_a = 0;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if ({a_a, b_a} == 2'b10) begin found = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (found == 0) begin errors++; $display("FAIL midreset_reach_vec2: got 0 expected 1"); end
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    checks++;
    if ({a_a, b_a, busy_a, done_a, pass_a, err_a, fvec_a, fbits_a} !== 14'd0) begin
      errors++;
      $display("FAIL midreset_state: got %0h expected 0",
               {a_a, b_a, busy_a, done_a, pass_a, err_a, fvec_a, fbits_a});
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done_a || busy_a) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin errors++; $display("FAIL midreset_quiet: got %0d expected 0", seen_done); end
    sb.push_back('{err: 4'd0, pass: 1'b1, fvec: 2'd0, fbits: 3'd0, lat: 17});
    sweep(0);
    x = sb.pop_front();
    checks++;
    if ({obs_lat, o_err, o_pass} !== {x.lat, x.err, x.pass}) begin
      errors++;
      $display("FAIL midreset_resweep: got lat=%0d err=%0d pass=%0d expected lat=%0d err=%0d pass=%0d",
               obs_lat, o_err, o_pass, x.lat, x.err, x.pass);
    end
  endtask

  task automatic test_held_start;
    int t[$];
    int bad_after = 0;
    int bad_pass = 0;
    int prev_done = 0;
`ifdef GATE_SWEEP_LOOP_EN
    int period = 17;
`else
    int period = 18;
`endif
    sel = 0; fm_a = 0;
    @(negedge clk); start_a = 1'b1;
    for (int k = 1; k <= 120 && t.size() < 3; k++) begin
      @(negedge clk);
      if (prev_done != 0 && {a_a, b_a} !== 2'b00) bad_after++;
      prev_done = 0;
      if (done_a) begin
        t.push_back(k);
        prev_done = 1;
        if (pass_a !== 1'b1) bad_pass++;
      end
    end
    @(negedge clk);
    if (prev_done != 0 && {a_a, b_a} !== 2'b00) bad_after++;
    start_a = 1'b0;
    checks++;
    if (t.size() !== 3) begin
      errors++; $display("FAIL loop_count: got %0d expected 3", t.size());
    end else begin
      if ((t[1] - t[0]) !== period || (t[2] - t[1]) !== period) begin
        errors++; $display("FAIL loop_period: got %0d,%0d expected %0d", t[1] - t[0], t[2] - t[1], period);
      end
    end
    checks++;
    if (bad_pass !== 0) begin errors++; $display("FAIL loop_pass: got %0d bad expected 0", bad_pass); end
    checks++;
    if (bad_after !== 0) begin errors++; $display("FAIL loop_ab_after_done: got %0d bad expected 0", bad_after); end
    repeat (25) @(negedge clk);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    fm_a = 0; fm_b = 0; sel = 0;
    test_reset();
    test_basic();
    test_e_stuck();
    test_saturate();
    test_hold1_busy_start();
    test_reset_mid();
    test_held_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gate_tt_sweeper.md
Name: gate_tt_sweeper

Overview:
Self-test sequencer wrapped around the two-input NAND/NOR/XOR gate stage. It drives the gate's a/b inputs through the full truth table (00, 01, 10, 11), holds each vector for a programmable settle time, and samples the gate's c/d/e outputs. It compares the samples against expected values, counts mismatching vectors and reports pass/fail. It sits directly upstream of the gate for stimulus and directly downstream of it for checking, on the lab board's single clock.

Parameters:
HOLD_CYCLES, 4, clock cycles each vector is held before sampling (legal range >= 1)
ERR_W, 4, width of the mismatch counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a sweep; sampled only in IDLE (and in DONE under the optional feature)
a  output  1  gate input a, registered
b  output  1  gate input b, registered
c  input  1  gate NAND output
d  input  1  gate NOR output
e  input  1  gate XOR output
busy  output  1  high while a sweep is in progress
done  output  1  one-cycle pulse at sweep end
pass  output  1  high after a sweep with zero mismatches; held until next accepted start
err_count  output  ERR_W  number of mismatching vectors in the last sweep, saturating
fail_vec  output  2  {a,b} of the first mismatching vector
fail_bits  output  3  {c,d,e} XOR expected, for the first mismatching vector

Behaviour:
- Reset, synchronous, active-high: state=IDLE; a=0, b=0; busy=0, done=0, pass=0; err_count=0, fail_vec=0, fail_bits=0; internal vector and hold counters=0.
- Reset asserted mid-sweep: abort immediately to the reset values above; no done pulse.
- Vector order: vec = 0,1,2,3 with a=vec[1], b=vec[0].
- Expected values: c=~(a&b), d=~(a|b), e=a^b, computed from the registered a/b.
- IDLE: a=b=0, busy=0.
  - start=1 -> DRIVE; next cycle vec=0, hold=0, busy=1.
  - Accepting start clears err_count, pass, fail_vec and fail_bits.
- DRIVE:
  - Hold counter increments each cycle.
  - When hold==HOLD_CYCLES-1, compare c/d/e that same cycle.
  - Any mismatch bit -> err_count+1, saturating at 2^ERR_W-1; count one per vector, not per bit.
  - If this is the first mismatch of the sweep, capture fail_vec={a,b} and fail_bits.
  - After the compare, if vec<3: vec+1, hold=0, new a/b visible next cycle. If vec==3: go to DONE.
  - HOLD_CYCLES=1: compare in the same cycle the vector is first driven; the gate is combinational, so this is legal.
- DONE (one cycle): done=1, busy=0, a=b=0. pass=1 iff no mismatch was recorded in the sweep, including the final vector. Then -> IDLE.
- Latency: start accepted at cycle T -> vector v driven on cycles T+1+v*H .. T+(v+1)*H, with H=HOLD_CYCLES -> done=1 at cycle T+4H+1.
- start is ignored while busy=1; holding start high across the sweep does not restart it (except under the optional feature).
- err_count, pass, fail_vec and fail_bits stay stable from DONE until the next accepted start.

Optional Feature:
GATE_SWEEP_LOOP_EN
- Defined: in DONE, if start=1, the block transitions directly to DRIVE with vec=0. It clears err_count, pass, fail_vec and fail_bits as in IDLE. done still pulses for that one cycle, and busy is 0 during that DONE cycle. Result: continuous sweeping while start is held.
- Undefined: DONE always returns to IDLE; start is sampled only in IDLE, so a held start restarts one cycle later, from IDLE.

Test Plan:
1. HOLD_CYCLES=4, correct gate, start pulse at cycle T -> a/b sequence 00,01,10,11 at 4 cycles each; done at T+17; pass=1, err_count=0, fail_vec=0, fail_bits=0.
2. e stuck at 0 -> mismatches on vectors 01 and 10; err_count=2, pass=0, fail_vec=2'b01, fail_bits=3'b001.
3. ERR_W=1, all three outputs inverted -> 4 mismatching vectors; err_count saturates at 1; fail_vec=2'b00, fail_bits=3'b111, pass=0.
4. HOLD_CYCLES=1, correct gate -> done exactly 5 cycles after start is accepted; extra start pulses while busy have no effect; exactly one done pulse.
5. rst asserted during vector 10 -> next cycle all outputs at reset values, no done; new start gives a clean full sweep with pass=1.
6. GATE_SWEEP_LOOP_EN defined, start held high, correct gate -> done pulses every 4H+1 cycles; a returns to 00 the cycle after done; pass=1 each sweep. Undefined: done period is 4H+2.
